// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl: double-buffered scaler configuration applied at frame start, with input frame/line monitoring
// Ports: clk, rst_n (async active-low); cfg_wr/cfg_adr/cfg_wdata write staging (0 h_step, 1 v_step, 2 inline_size);
// cfg_commit requests apply at the next frame start, cfg_busy while not yet applied; err_clr clears sticky flags;
// de_i/hs_i/vs_i input timing; reg_* active configuration; cfg_applied pulses when it changes;
// frame_cnt frames started; line_size pixels of last line; err_step rejected commit; err_line oversized line.
module scaler_cfg_ctrl #(
  parameter logic [15:0] SCALE_STEP = 16'd128,
  parameter logic [15:0] LINE_IN_SIZE_MAX = 16'd1024,
  parameter logic [15:0] INLINE_SIZE_DEF = 16'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_adr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  input  logic        err_clr,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [15:0] reg_h_scale_step,
  output logic [15:0] reg_v_scale_step,
  output logic [15:0] reg_v_scale_inline_size,
  output logic        cfg_applied,
  output logic [15:0] frame_cnt,
  output logic [15:0] line_size,
  output logic        err_step,
  output logic        err_line
);
  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;
  state_t state, state_nx;
  logic [15:0] stg_h, stg_v, stg_i, pix;
  logic vs_q, hs_q, frame_start, line_end, step_ok, step_bad, line_bad, do_apply;
  always_comb begin
    frame_start = vs_i & ~vs_q;
    line_end = hs_i & ~hs_q;
    step_ok = (stg_h != 16'd0) && (stg_v != 16'd0);
    step_bad = (state == IDLE) && cfg_commit && !step_ok;
    line_bad = line_end && (pix > LINE_IN_SIZE_MAX);
    do_apply = (state == PEND) && frame_start;
    state_nx = state;
    case (state)
      IDLE: state_nx = (cfg_commit && step_ok) ? PEND : IDLE;
      PEND: state_nx = frame_start ? APPLY : PEND;
      default: state_nx = IDLE;
    endcase
    cfg_busy = state != IDLE;
    cfg_applied = state == APPLY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Active set is loaded on the edge entering APPLY so it is visible together with the cfg_applied pulse.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg_h <= SCALE_STEP;
      stg_v <= SCALE_STEP;
      stg_i <= INLINE_SIZE_DEF;
      reg_h_scale_step <= SCALE_STEP;
      reg_v_scale_step <= SCALE_STEP;
      reg_v_scale_inline_size <= INLINE_SIZE_DEF;
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      frame_cnt <= 16'd0;
      line_size <= 16'd0;
      pix <= 16'd0;
      err_step <= 1'b0;
      err_line <= 1'b0;
    end else begin
      if (cfg_wr && cfg_adr == 2'd0) stg_h <= cfg_wdata;
      if (cfg_wr && cfg_adr == 2'd1) stg_v <= cfg_wdata;
      if (cfg_wr && cfg_adr == 2'd2) stg_i <= cfg_wdata;
      if (do_apply) begin
        reg_h_scale_step <= stg_h;
        reg_v_scale_step <= stg_v;
        reg_v_scale_inline_size <= stg_i;
      end
      vs_q <= vs_i;
      hs_q <= hs_i;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (line_end) line_size <= pix;
      pix <= hs_i ? 16'd0 : (de_i && pix != 16'hFFFF) ? pix + 16'd1 : pix;
      err_step <= step_bad | (err_step & ~err_clr);
      err_line <= line_bad | (err_line & ~err_clr);
    end
endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// tb_scaler_cfg_ctrl: directed and randomized checks of scaler_cfg_ctrl against a behavioural model
module tb_scaler_cfg_ctrl;
  logic clk = 1'b0;
  logic rst_n, cfg_wr, cfg_commit, err_clr, de_i, hs_i, vs_i;
  logic [1:0] cfg_adr;
  logic [15:0] cfg_wdata;
  logic cfg_busy, cfg_applied, err_step, err_line;
  logic [15:0] reg_h, reg_v, reg_i, frame_cnt, line_size;
  int nv = 0, nf = 0, pulses = 0;
  logic [15:0] m_stg [3], m_act [3];
  logic [15:0] m_fc, m_ls, m_pix;
  logic m_pend, m_app, m_es, m_el, m_vs, m_hs;

  scaler_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_adr(cfg_adr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .err_clr(err_clr), .de_i(de_i), .hs_i(hs_i),
    .vs_i(vs_i), .reg_h_scale_step(reg_h), .reg_v_scale_step(reg_v), .reg_v_scale_inline_size(reg_i),
    .cfg_applied(cfg_applied), .frame_cnt(frame_cnt), .line_size(line_size), .err_step(err_step),
    .err_line(err_line)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cfg_applied) pulses++;
  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic model_reset();
    m_stg = '{16'd128, 16'd128, 16'd12};
    m_act = '{16'd128, 16'd128, 16'd12};
    m_fc = 0; m_ls = 0; m_pix = 0;
    m_pend = 0; m_app = 0; m_es = 0; m_el = 0; m_vs = 0; m_hs = 0;
  endtask

  // Drive one cycle of inputs and advance the model by the spec's rules.
  task automatic step(input logic wr, input logic [1:0] adr, input logic [15:0] wd, input logic cm,
                      input logic clr, input logic de, input logic hs, input logic vs);
    logic fs, hr;
    @(negedge clk);
    cfg_wr = wr; cfg_adr = adr; cfg_wdata = wd; cfg_commit = cm; err_clr = clr;
    de_i = de; hs_i = hs; vs_i = vs;
    @(posedge clk);
    fs = vs && !m_vs;
    hr = hs && !m_hs;
    if (clr) begin m_es = 0; m_el = 0; end
    if (m_app) m_app = 0;
    else if (m_pend) begin
      if (fs) begin m_act = m_stg; m_pend = 0; m_app = 1; end
    end else if (cm) begin
      if (m_stg[0] != 0 && m_stg[1] != 0) m_pend = 1;
      else m_es = 1;
    end
    if (fs) m_fc = m_fc + 16'd1;
    if (hr) begin
      m_ls = m_pix;
      if (m_pix > 16'd1024) m_el = 1;
    end
    if (hs) m_pix = 0;
    else if (de && m_pix != 16'hFFFF) m_pix = m_pix + 16'd1;
    if (wr && adr != 2'd3) m_stg[adr] = wd;
    m_vs = vs; m_hs = hs;
    #1;
  endtask

  task automatic vid(input logic de, input logic hs, input logic vs);
    step('0, 2'd0, 16'd0, '0, '0, de, hs, vs);
  endtask

  task automatic line(input int n, input logic clr);
    for (int i = 0; i < n; i++) vid('1, '0, '1);
    step('0, 2'd0, 16'd0, '0, clr, '0, '1, '1);
    vid('0, '1, '1);
  endtask

  task automatic vgap();
    vid('0, '1, '0);
    vid('0, '1, '0);
  endtask

  task automatic test_reset();
    nv++; if (cfg_busy !== 1'b0 || cfg_applied !== 1'b0) begin nf++; $display("FAIL reset_flags busy=%b applied=%b want 0 0", cfg_busy, cfg_applied); end
    nv++; if ({reg_h, reg_v, reg_i} !== {16'd128, 16'd128, 16'd12}) begin nf++; $display("FAIL reset_regs got %0d/%0d/%0d want 128/128/12", reg_h, reg_v, reg_i); end
    nv++; if ({frame_cnt, line_size, err_step, err_line} !== 34'd0) begin nf++; $display("FAIL reset_cnt fc=%0d ls=%0d es=%b el=%b want 0", frame_cnt, line_size, err_step, err_line); end
  endtask

  task automatic test_apply();
    vgap(); vid('0, '1, '1); line(4, '0);
    step('1, 2'd0, 16'd243, '0, '0, '0, '0, '1);
    step('1, 2'd1, 16'd243, '0, '0, '0, '0, '1);
    step('1, 2'd2, 16'd12, '0, '0, '0, '0, '1);
    step('0, 2'd0, 16'd0, '1, '0, '0, '0, '1);
    nv++; if (cfg_busy !== 1'b1) begin nf++; $display("FAIL apply_busy got %b want 1", cfg_busy); end
    line(4, '0); vgap();
    nv++; if ({reg_h, reg_v} !== {16'd128, 16'd128}) begin nf++; $display("FAIL apply_hold got %0d/%0d want 128/128", reg_h, reg_v); end
    pulses = 0;
    vid('0, '1, '1);
    nv++; if ({reg_h, reg_v, reg_i, cfg_applied} !== {16'd243, 16'd243, 16'd12, 1'b1}) begin nf++; $display("FAIL apply_regs got %0d/%0d/%0d applied=%b want 243/243/12 1", reg_h, reg_v, reg_i, cfg_applied); end
    line(4, '0);
    nv++; if (pulses !== 1 || cfg_busy !== 1'b0) begin nf++; $display("FAIL apply_pulse pulses=%0d busy=%b want 1 0", pulses, cfg_busy); end
  endtask

  task automatic test_err_step();
    step('1, 2'd1, 16'd0, '0, '0, '0, '0, '1);
    step('0, 2'd0, 16'd0, '1, '0, '0, '0, '1);
    nv++; if ({err_step, cfg_busy, reg_h, reg_v} !== {1'b1, 1'b0, 16'd243, 16'd243}) begin nf++; $display("FAIL err_step_set es=%b busy=%b h=%0d v=%0d want 1 0 243 243", err_step, cfg_busy, reg_h, reg_v); end
    step('0, 2'd0, 16'd0, '0, '1, '0, '0, '1);
    nv++; if (err_step !== 1'b0) begin nf++; $display("FAIL err_step_clr got %b want 0", err_step); end
    step('1, 2'd1, 16'd243, '0, '0, '0, '0, '1);
  endtask

  task automatic test_commit_on_fs();
    step('1, 2'd0, 16'd100, '0, '0, '0, '0, '1);
    vgap(); pulses = 0;
    step('0, 2'd0, 16'd0, '1, '0, '0, '1, '1);
    nv++; if ({cfg_busy, cfg_applied, reg_h} !== {1'b1, 1'b0, 16'd243}) begin nf++; $display("FAIL fs_commit busy=%b applied=%b h=%0d want 1 0 243", cfg_busy, cfg_applied, reg_h); end
    line(4, '0); vgap();
    nv++; if (reg_h !== 16'd243 || pulses !== 0) begin nf++; $display("FAIL fs_commit_wait h=%0d pulses=%0d want 243 0", reg_h, pulses); end
    vid('0, '1, '1);
    nv++; if (reg_h !== 16'd100 || cfg_applied !== 1'b1) begin nf++; $display("FAIL fs_commit_apply h=%0d applied=%b want 100 1", reg_h, cfg_applied); end
    line(2, '0);
  endtask

  task automatic test_latest_write();
    step('0, 2'd0, 16'd0, '1, '0, '0, '0, '1);
    step('1, 2'd0, 16'd200, '0, '0, '0, '0, '1);
    step('1, 2'd0, 16'd300, '0, '0, '0, '0, '1);
    line(3, '0); vgap(); vid('0, '1, '1);
    nv++; if (reg_h !== 16'd300) begin nf++; $display("FAIL latest_write h=%0d want 300", reg_h); end
    line(2, '0);
  endtask

  task automatic test_lines();
    line(24, '0);
    nv++; if (line_size !== 16'd24 || err_line !== 1'b0) begin nf++; $display("FAIL line_24 ls=%0d el=%b want 24 0", line_size, err_line); end
    line(1024, '0);
    nv++; if (line_size !== 16'd1024 || err_line !== 1'b0) begin nf++; $display("FAIL line_1024 ls=%0d el=%b want 1024 0", line_size, err_line); end
    line(1025, '0);
    nv++; if (line_size !== 16'd1025 || err_line !== 1'b1) begin nf++; $display("FAIL line_1025 ls=%0d el=%b want 1025 1", line_size, err_line); end
    step('0, 2'd0, 16'd0, '0, '1, '0, '0, '1);
    nv++; if (err_line !== 1'b0) begin nf++; $display("FAIL line_clr el=%b want 0", err_line); end
    line(1025, '1);
    nv++; if (err_line !== 1'b1) begin nf++; $display("FAIL line_set_wins el=%b want 1", err_line); end
  endtask

  task automatic test_reset_pend();
    step('0, 2'd0, 16'd0, '1, '0, '0, '0, '1);
    nv++; if (cfg_busy !== 1'b1) begin nf++; $display("FAIL rst_pend_busy got %b want 1", cfg_busy); end
    @(negedge clk);
    vs_i = 0; hs_i = 0; de_i = 0; cfg_commit = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    nv++; if ({cfg_busy, cfg_applied, reg_h, reg_v, reg_i, frame_cnt, line_size, err_step, err_line} !== {2'b00, 16'd128, 16'd128, 16'd12, 32'd0, 2'b00}) begin nf++; $display("FAIL rst_async busy=%b h=%0d v=%0d i=%0d fc=%0d ls=%0d es=%b el=%b", cfg_busy, reg_h, reg_v, reg_i, frame_cnt, line_size, err_step, err_line); end
    @(negedge clk); rst_n = 1;
    pulses = 0;
    for (int f = 0; f < 3; f++) begin vgap(); vid('0, '1, '1); line(3, '0); end
    nv++; if (pulses !== 0 || frame_cnt !== 16'd3 || cfg_busy !== 1'b0) begin nf++; $display("FAIL rst_no_apply pulses=%0d fc=%0d busy=%b want 0 3 0", pulses, frame_cnt, cfg_busy); end
  endtask

  task automatic test_random();
    logic rv = 1'b0;
    logic h, d;
    logic [83:0] got, exp;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      h = ($urandom_range(0, 5) == 0);
      d = !h && ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, d, h, rv);
      got = {cfg_busy, cfg_applied, reg_h, reg_v, reg_i, frame_cnt, line_size, err_step, err_line};
      exp = {m_pend | m_app, m_app, m_act[0], m_act[1], m_act[2], m_fc, m_ls, m_es, m_el};
      nv++; if (got !== exp) begin nf++; $display("FAIL random cycle %0d got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    rst_n = 0; cfg_wr = 0; cfg_adr = 0; cfg_wdata = 0; cfg_commit = 0; err_clr = 0;
    de_i = 0; hs_i = 0; vs_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_apply();
    test_err_step();
    test_commit_on_fs();
    test_latest_write();
    test_lines();
    test_reset_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
